// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding, array instruction codes and phase-counter sizing
// for the MAC array sequencer.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Wide enough for the longest phase (LOAD/SETTLE, DRAIN or a full-range EXEC).
    function automatic int phase_width(input int n_row, input int n_col, input int n_len_bw);
        int span;
        span = 2 * n_col;
        if (n_row + n_col > span) span = n_row + n_col;
        if ((1 << n_len_bw) > span) span = 1 << n_len_bw;
        return $clog2(span) + 1;
    endfunction

endpackage

// File: rtl/inst_skew.sv
// Instruction skew chain: row r receives the row-0 command delayed by r cycles,
// so every row of the MAC array sees the same sequence one cycle after the row above.
module inst_skew #(
    parameter int row = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cmd_p0,
    output logic [2*row-1:0] inst_w
);

    assign inst_w[1:0] = cmd_p0;

    generate
        if (row > 1) begin : g_chain
            logic [1:0] skew_q [row-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < row - 1; i++) skew_q[i] <= 2'b00;
                end else begin
                    skew_q[0] <= cmd_p0;
                    for (int i = 1; i < row - 1; i++) skew_q[i] <= skew_q[i-1];
                end
            end

            for (genvar r = 1; r < row; r++) begin : g_tap
                assign inst_w[2*r+1:2*r] = skew_q[r-1];
            end
        end
    endgenerate

endmodule

// File: rtl/mac_array_ctrl.sv
// Load/execute/drain sequencer for the mac_row array. Optional busy-cycle
// counter output perf_cycles is built when MAC_CTRL_PERF_CNT_EN is defined.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [len_bw-1:0]  num_exec,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    output logic               w_rd_en,
    output logic [addr_bw-1:0] w_addr,
    output logic               x_rd_en,
    output logic [addr_bw-1:0] x_addr,
    output logic [2*row-1:0]   inst_w,
    output logic               busy,
    output logic               done
`ifdef MAC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    localparam int CW = phase_width(row, col, len_bw);

    state_t             state_q, state_d;
    logic [CW-1:0]      phase_q;
    logic               phase_last;
    logic [len_bw-1:0]  num_q;
    logic [addr_bw-1:0] w_base_q;
    logic [addr_bw-1:0] x_base_q;
    logic [1:0]         cmd_p0;
    logic               start_acc;

    assign start_acc = (state_q == IDLE) && start;

    // A zero-length EXEC never reaches this compare: SETTLE skips straight to DRAIN.
    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            LOAD, SETTLE: phase_last = (phase_q == CW'(col - 1));
            EXEC:         phase_last = (phase_q == (CW'(num_q) - CW'(1)));
            DRAIN:        phase_last = (phase_q == CW'(row + col - 1));
            default:      phase_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (phase_last) state_d = SETTLE;
            SETTLE:  if (phase_last) state_d = (num_q != '0) ? EXEC : DRAIN;
            EXEC:    if (phase_last) state_d = DRAIN;
            DRAIN:   if (phase_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = (state_q == LOAD);
        x_rd_en = (state_q == EXEC);
        w_addr  = '0;
        x_addr  = '0;
        if (w_rd_en) w_addr = w_base_q + addr_bw'(phase_q);
        if (x_rd_en) x_addr = x_base_q + addr_bw'(phase_q);
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            num_q    <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || (state_q == IDLE)) phase_q <= '0;
            else phase_q <= phase_q + CW'(1);
            if (start_acc) begin
                num_q    <= num_exec;
                w_base_q <= w_base;
                x_base_q <= x_base;
            end
        end
    end

    // Stage p0: row-0 command lags the read enable by the SRAM read latency.
    always_ff @(posedge clk) begin
        if (reset) cmd_p0 <= INST_NOP;
        else if (w_rd_en) cmd_p0 <= INST_LOAD;
        else if (x_rd_en) cmd_p0 <= INST_EXEC;
        else cmd_p0 <= INST_NOP;
    end

    inst_skew #(
        .row(row)
    ) u_skew (
        .clk    (clk),
        .reset  (reset),
        .cmd_p0 (cmd_p0),
        .inst_w (inst_w)
    );

`ifdef MAC_CTRL_PERF_CNT_EN
    // Starts at 1 for the first busy cycle; DONE is the last cycle counted.
    always_ff @(posedge clk) begin
        if (reset) perf_cycles <= '0;
        else if (start_acc) perf_cycles <= 32'd1;
        else if (busy && (state_q != DONE) && (perf_cycles != '1))
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl (row=col=8, addr_bw=11, len_bw=8).
// Cycle k of a pass is the cycle following the k-1'th edge after the start edge.
module tb_mac_array_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int ABW  = 11;
    localparam int LBW  = 8;
    localparam int CAPN = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [LBW-1:0] num_exec = '0;
    logic [ABW-1:0] w_base = '0;
    logic [ABW-1:0] x_base = '0;
    logic           w_rd_en, x_rd_en, busy, done;
    logic [ABW-1:0] w_addr, x_addr;
    logic [2*ROW-1:0] inst_w;
`ifdef MAC_CTRL_PERF_CNT_EN
    logic [31:0]    perf_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic             c_wen   [CAPN];
    logic             c_xen   [CAPN];
    logic             c_busy  [CAPN];
    logic             c_done  [CAPN];
    logic [ABW-1:0]   c_waddr [CAPN];
    logic [ABW-1:0]   c_xaddr [CAPN];
    logic [2*ROW-1:0] c_inst  [CAPN];

    always #5 clk = ~clk;

    mac_array_ctrl #(
        .row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_exec (num_exec),
        .w_base   (w_base),
        .x_base   (x_base),
        .w_rd_en  (w_rd_en),
        .w_addr   (w_addr),
        .x_rd_en  (x_rd_en),
        .x_addr   (x_addr),
        .inst_w   (inst_w),
        .busy     (busy),
        .done     (done)
`ifdef MAC_CTRL_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    // Expected {w_rd_en, x_rd_en, busy, done, inst_w} for cycle k of a pass with n vectors.
    function automatic logic [2*ROW+3:0] exp_ctl(input int k, input int n);
        int dc;
        int j;
        logic [2*ROW-1:0] iw;
        dc = 2*COL + n + ROW + COL + 1;
        for (int r = 0; r < ROW; r++) begin
            j = k - r;
            if (j >= 2 && j <= COL + 1) iw[2*r +: 2] = 2'b01;
            else if (j >= 2*COL + 2 && j <= 2*COL + n + 1) iw[2*r +: 2] = 2'b10;
            else iw[2*r +: 2] = 2'b00;
        end
        return {(k >= 1 && k <= COL), (k >= 2*COL + 1 && k <= 2*COL + n),
                (k >= 1 && k <= dc), (k == dc), iw};
    endfunction

    function automatic logic [2*ROW+3:0] got_ctl(input int k);
        return {c_wen[k], c_xen[k], c_busy[k], c_done[k], c_inst[k]};
    endfunction

    task automatic capture(input int n, input logic [ABW-1:0] wb, input logic [ABW-1:0] xb,
                           input int ncyc, input bit hold);
        @(negedge clk);
        start = 1'b1;
        num_exec = LBW'(n);
        w_base = wb;
        x_base = xb;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            c_wen[k] = w_rd_en;   c_xen[k] = x_rd_en;
            c_busy[k] = busy;     c_done[k] = done;
            c_waddr[k] = w_addr;  c_xaddr[k] = x_addr;
            c_inst[k] = inst_w;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (w_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_rd_en got=%b exp=0", w_rd_en); end
        n_checks++; if (x_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_x_rd_en got=%b exp=0", x_rd_en); end
        n_checks++; if (w_addr !== '0) begin n_fail++; $display("FAIL reset_w_addr got=%h exp=0", w_addr); end
        n_checks++; if (x_addr !== '0) begin n_fail++; $display("FAIL reset_x_addr got=%h exp=0", x_addr); end
        n_checks++; if (inst_w !== '0) begin n_fail++; $display("FAIL reset_inst_w got=%h exp=0", inst_w); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef MAC_CTRL_PERF_CNT_EN
        n_checks++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf got=%0d exp=0", perf_cycles); end
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int first_done;
        int n_done;
        capture(4, 11'h010, 11'h100, 40, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (c_wen[k] !== 1'b1 || c_waddr[k] !== 11'h010 + ABW'(k - 1)) begin
                n_fail++; $display("FAIL basic_w_addr cyc=%0d got=%b/%h exp=1/%h", k, c_wen[k], c_waddr[k], 11'h010 + ABW'(k - 1));
            end
        end
        for (int k = 17; k <= 20; k++) begin
            n_checks++;
            if (c_xen[k] !== 1'b1 || c_xaddr[k] !== 11'h100 + ABW'(k - 17)) begin
                n_fail++; $display("FAIL basic_x_addr cyc=%0d got=%b/%h exp=1/%h", k, c_xen[k], c_xaddr[k], 11'h100 + ABW'(k - 17));
            end
        end
        for (int k = 24; k <= 29; k++) begin
            n_checks++;
            if (c_inst[k][15:14] !== ((k >= 25 && k <= 28) ? 2'b10 : 2'b00)) begin
                n_fail++; $display("FAIL basic_row7 cyc=%0d got=%b exp=%b", k, c_inst[k][15:14], (k >= 25 && k <= 28) ? 2'b10 : 2'b00);
            end
        end
        first_done = 0;
        n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            if (c_done[k] === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
        end
        n_checks++;
        if (first_done != 37 || n_done != 1) begin
            n_fail++; $display("FAIL basic_done got=cyc%0d x%0d exp=cyc37 x1", first_done, n_done);
        end
        for (int k = 1; k <= 40; k++) begin
            n_checks++;
            if (got_ctl(k) !== exp_ctl(k, 4)) begin
                n_fail++; $display("FAIL basic_ctl cyc=%0d got=%h exp=%h", k, got_ctl(k), exp_ctl(k, 4));
            end
            n_checks++;
            if ((!c_wen[k] && c_waddr[k] !== '0) || (!c_xen[k] && c_xaddr[k] !== '0)) begin
                n_fail++; $display("FAIL basic_addr_idle cyc=%0d got=%h/%h exp=0/0", k, c_waddr[k], c_xaddr[k]);
            end
        end
    endtask

    task automatic test_n_zero();
        capture(0, 11'h020, 11'h200, 36, 1'b0);
        for (int k = 1; k <= 36; k++) begin
            n_checks++;
            if (c_xen[k] !== 1'b0 || c_xaddr[k] !== '0) begin
                n_fail++; $display("FAIL nzero_x cyc=%0d got=%b/%h exp=0/0", k, c_xen[k], c_xaddr[k]);
            end
            n_checks++;
            if (c_done[k] !== (k == 33)) begin
                n_fail++; $display("FAIL nzero_done cyc=%0d got=%b exp=%b", k, c_done[k], k == 33);
            end
            n_checks++;
            if (got_ctl(k) !== exp_ctl(k, 0)) begin
                n_fail++; $display("FAIL nzero_ctl cyc=%0d got=%h exp=%h", k, got_ctl(k), exp_ctl(k, 0));
            end
        end
    endtask

    task automatic test_wrap();
        logic [ABW-1:0] wexp [8];
        logic [ABW-1:0] xexp [3];
        wexp = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
        xexp = '{11'h7FE, 11'h7FF, 11'h000};
        capture(3, 11'h7FC, 11'h7FE, 38, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if (c_wen[k] !== 1'b1 || c_waddr[k] !== wexp[k-1]) begin
                n_fail++; $display("FAIL wrap_w_addr cyc=%0d got=%b/%h exp=1/%h", k, c_wen[k], c_waddr[k], wexp[k-1]);
            end
        end
        for (int k = 17; k <= 19; k++) begin
            n_checks++;
            if (c_xen[k] !== 1'b1 || c_xaddr[k] !== xexp[k-17]) begin
                n_fail++; $display("FAIL wrap_x_addr cyc=%0d got=%b/%h exp=1/%h", k, c_xen[k], c_xaddr[k], xexp[k-17]);
            end
        end
        for (int k = 1; k <= 38; k++) begin
            n_checks++;
            if (got_ctl(k) !== exp_ctl(k, 3)) begin
                n_fail++; $display("FAIL wrap_ctl cyc=%0d got=%h exp=%h", k, got_ctl(k), exp_ctl(k, 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        bit seen;
        capture(4, 11'h050, 11'h150, 46, 1'b1);
        start = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            n_checks++;
            if (got_ctl(k) !== exp_ctl(k, 4)) begin
                n_fail++; $display("FAIL b2b_first_ctl cyc=%0d got=%h exp=%h", k, got_ctl(k), exp_ctl(k, 4));
            end
        end
        n_done = 0;
        for (int k = 1; k <= 46; k++) if (c_done[k] === 1'b1) n_done++;
        n_checks++;
        if (n_done != 1) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=1", n_done); end
        for (int k = 39; k <= 46; k++) begin
            n_checks++;
            if (c_wen[k] !== 1'b1 || c_waddr[k] !== 11'h050 + ABW'(k - 39) || c_busy[k] !== 1'b1) begin
                n_fail++; $display("FAIL b2b_second_load cyc=%0d got=%b/%h exp=1/%h", k, c_wen[k], c_waddr[k], 11'h050 + ABW'(k - 39));
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL b2b_second_done got=timeout exp=done"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit bad_done;
        bit bad_busy;
        @(negedge clk);
        start = 1'b1; num_exec = 8'd4; w_base = 11'h060; x_base = 11'h160;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        n_checks++;
        if (x_rd_en !== 1'b1 || x_addr !== 11'h161) begin
            n_fail++; $display("FAIL rstmid_in_exec got=%b/%h exp=1/161", x_rd_en, x_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({w_rd_en, x_rd_en, busy, done} !== 4'b0000 || w_addr !== '0 || x_addr !== '0 || inst_w !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs got=%b%b%b%b/%h/%h/%h exp=0000/0/0/0", w_rd_en, x_rd_en, busy, done, w_addr, x_addr, inst_w);
        end
        @(negedge clk);
        reset = 1'b0;
        bad_done = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) bad_done = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        n_checks++;
        if (bad_done) begin n_fail++; $display("FAIL rstmid_no_done got=done exp=none"); end
        n_checks++;
        if (bad_busy) begin n_fail++; $display("FAIL rstmid_idle got=busy exp=idle"); end
        capture(4, 11'h040, 11'h300, 40, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            n_checks++;
            if (got_ctl(k) !== exp_ctl(k, 4)) begin
                n_fail++; $display("FAIL rstmid_fresh_ctl cyc=%0d got=%h exp=%h", k, got_ctl(k), exp_ctl(k, 4));
            end
        end
        for (int k = 17; k <= 20; k++) begin
            n_checks++;
            if (c_xaddr[k] !== 11'h300 + ABW'(k - 17)) begin
                n_fail++; $display("FAIL rstmid_fresh_x_addr cyc=%0d got=%h exp=%h", k, c_xaddr[k], 11'h300 + ABW'(k - 17));
            end
        end
    endtask

`ifdef MAC_CTRL_PERF_CNT_EN
    task automatic test_perf();
        capture(4, 11'h010, 11'h100, 40, 1'b0);
        n_checks++;
        if (perf_cycles !== 32'd37) begin n_fail++; $display("FAIL perf_final got=%0d exp=37", perf_cycles); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (perf_cycles !== 32'd37) begin n_fail++; $display("FAIL perf_hold got=%0d exp=37", perf_cycles); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_n_zero();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef MAC_CTRL_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencer for the 2-D MAC array built from `mac_row` instances. It fetches a kernel from weight SRAM and drives the kernel-load instruction. It then streams activations with the execute instruction and drains the array, skewing the 2-bit instruction by one cycle per row so that each row sees the same sequence one cycle after the row above. It sits between the top-level core FSM, which issues `start` and waits for `done`, and the array, weight SRAM and activation SRAM.

## Interface
Parameters:
- `row`, 8, number of mac_row instances driven
- `col`, 8, columns per row; kernel words per load
- `addr_bw`, 11, SRAM address width
- `len_bw`, 8, width of execute-length field

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  request a load/execute pass; sampled only in IDLE
- `num_exec`  in  `len_bw`  activation vectors to stream (N); captured with `start`
- `w_base`  in  `addr_bw`  first weight address; captured with `start`
- `x_base`  in  `addr_bw`  first activation address; captured with `start`
- `w_rd_en`  out  1  weight SRAM read enable
- `w_addr`  out  `addr_bw`  weight SRAM address
- `x_rd_en`  out  1  activation SRAM read enable
- `x_addr`  out  `addr_bw`  activation SRAM address
- `inst_w`  out  `2*row`  per-row instruction; row r at bits [2r+1:2r]; bit1 execute, bit0 kernel load
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at pass completion

## Operation
- FSM states: IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE.
- IDLE: `start`=1 captures `num_exec`/`w_base`/`x_base` and moves to LOAD. A `start` seen in any other state is ignored.
- LOAD: lasts `col` cycles. `w_rd_en`=1, `w_addr` = w_base+k for k=0..col-1. Then SETTLE.
- SETTLE: lasts `col` cycles with no reads. Then EXEC if N>0, else DRAIN.
- EXEC: lasts N cycles. `x_rd_en`=1, `x_addr` = x_base+k for k=0..N-1. Then DRAIN.
- DRAIN: lasts `row+col` cycles with no reads. Then DONE.
- DONE: one cycle with `done`=1, then IDLE.
- Address arithmetic is modulo 2^`addr_bw`; a wrap past the top address is legal and silent.
- Row-0 command is registered one cycle after the matching read enable, matching SRAM 1-cycle read latency:
  - 01 for the cycle after each LOAD read
  - 10 for the cycle after each EXEC read
  - 00 otherwise
- Row r command equals row-0 command delayed r cycles. Commands are never 11.
- Phase counter width is ceil(log2(max(2*col, row+col, 2^len_bw)))+1 bits.
- Reset has priority over everything, including when asserted mid-pass. Next cycle: state IDLE, skew pipeline cleared, pass aborted, no `done`.

## Timing
- Reset values: `w_rd_en`=0, `x_rd_en`=0, `w_addr`=0, `x_addr`=0, `inst_w`=0, `busy`=0, `done`=0.
- Read addresses are 0 whenever the matching enable is low.
- With `start` accepted at edge t and N activation vectors:
  - LOAD occupies cycles t+1..t+col.
  - Row-0 `inst_w` = 01 in cycles t+2..t+col+1.
  - SETTLE occupies t+col+1..t+2col.
  - EXEC occupies t+2col+1..t+2col+N.
  - Row-0 `inst_w` = 10 in cycles t+2col+2..t+2col+N+1.
  - DRAIN follows EXEC for `row+col` cycles.
  - `done` fires at cycle t+2col+N+row+col+1.
- `busy` rises at t+1 and falls the cycle after `done`.
- A new `start` may be presented in the cycle right after `done` (IDLE), giving back-to-back passes with one idle cycle between them.

## Configuration
- `MAC_CTRL_PERF_CNT_EN` defined:
  - Adds output `perf_cycles` (32 bits), reset 0.
  - Cleared to 1 on the cycle `start` is accepted, then increments every busy cycle.
  - Holds its final value (= total busy cycles including DONE) until the next accepted `start`.
  - Saturates at 2^32-1.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `mac_ctrl_pkg`:
  - state enum (IDLE, LOAD, SETTLE, EXEC, DRAIN, DONE)
  - instruction constants INST_NOP=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10
- Sub-module `inst_skew`:
  - parameter `row`
  - input: row-0 2-bit command
  - output: `2*row` bus
  - chain of `row-1` 2-bit registers with the same synchronous reset
- FSM, counters and address generators stay in `mac_array_ctrl`.

## Test plan
- row=col=8, N=4, w_base=0x010, x_base=0x100, `start` at edge 0:
  - `w_addr` 0x010..0x017 in cycles 1..8
  - `x_addr` 0x100..0x103 in cycles 17..20
  - `done` at cycle 37
  - row-7 `inst_w` = 10 in cycles 25..28
- N=0: no `x_rd_en` ever; `done` at cycle 33.
- w_base=0x7FC, addr_bw=11: `w_addr` sequence 0x7FC,0x7FD,0x7FE,0x7FF,0x000..0x003.
- `start` held high throughout a pass: exactly one pass per IDLE visit; second pass LOAD begins the cycle after IDLE.
- `reset` asserted during EXEC: next cycle all outputs 0 and `busy`=0; no `done`; a fresh `start` runs a normal full pass.
- With `MAC_CTRL_PERF_CNT_EN`, row=col=8, N=4: `perf_cycles`=37 after `done` and holds it while IDLE.
